// File: rtl/memory_bist_ctrl.sv
// Built-in self-test initiator for a single-port memory with a shared bidirectional data bus.
// Writes a seeded arithmetic pattern, reads it back, and optionally repeats with the pattern inverted.
module memory_bist_ctrl #(
   parameter int                ADDR_W       = 4,
   parameter int                DATA_W       = 8,
   parameter int                RD_LAT       = 2,
   parameter logic [DATA_W-1:0] PATTERN_STEP = 'h11,
   parameter bit                TWO_PASS     = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] seed,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [5:0]        err_count,
   output logic              first_err_valid,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic              mem_we,
   output logic              mem_oe,
   output logic [ADDR_W-1:0] mem_addr,
   inout  wire  [DATA_W-1:0] mem_data
);

   localparam int                LAT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [LAT_W-1:0]  LAT_LAST = LAT_W'(RD_LAT - 1);
   localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_TURN_W,
      S_READ,
      S_TURN_R,
      S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LAT_W-1:0]    lat_q, lat_d;
   logic                inv_q, inv_d;
   logic [DATA_W-1:0]   seed_q, seed_d;
   logic [5:0]          err_q, err_d;
   logic                fev_q, fev_d;
   logic [ADDR_W-1:0]   fea_q, fea_d;
   logic                pass_q, pass_d;

   logic [DATA_W-1:0]   addr_ext;
   logic [DATA_W-1:0]   pattern;
   logic                mismatch;

   // Pattern for the current address; the second pass uses its bitwise inverse.
   assign addr_ext = DATA_W'(addr_q);
   assign pattern  = inv_q ? ~(seed_q + addr_ext * PATTERN_STEP)
                           :  (seed_q + addr_ext * PATTERN_STEP);

   // Case inequality so an undriven or unknown bus bit counts as a mismatch in simulation.
   assign mismatch = (mem_data !== pattern);

   assign mem_data        = mem_we ? pattern : {DATA_W{1'bz}};
   assign mem_addr        = addr_q;
   assign pass            = pass_q;
   assign err_count       = err_q;
   assign first_err_valid = fev_q;
   assign first_err_addr  = fea_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         lat_q   <= '0;
         inv_q   <= 1'b0;
         seed_q  <= '0;
         err_q   <= '0;
         fev_q   <= 1'b0;
         fea_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         lat_q   <= lat_d;
         inv_q   <= inv_d;
         seed_q  <= seed_d;
         err_q   <= err_d;
         fev_q   <= fev_d;
         fea_q   <= fea_d;
         pass_q  <= pass_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      lat_d   = lat_q;
      inv_d   = inv_q;
      seed_d  = seed_q;
      err_d   = err_q;
      fev_d   = fev_q;
      fea_d   = fea_q;
      pass_d  = pass_q;
      busy    = 1'b0;
      done    = 1'b0;
      mem_we  = 1'b0;
      mem_oe  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               seed_d  = seed;
               err_d   = '0;
               fev_d   = 1'b0;
               fea_d   = '0;
               pass_d  = 1'b0;
               addr_d  = '0;
               lat_d   = '0;
               inv_d   = 1'b0;
               state_d = S_WRITE;
            end
         end
         S_WRITE: begin
            busy   = 1'b1;
            mem_we = 1'b1;
            if (addr_q == ADDR_MAX) begin
               addr_d  = '0;
               state_d = S_TURN_W;
            end else begin
               addr_d = addr_q + 1'b1;
            end
         end
         S_TURN_W: begin
            busy    = 1'b1;
            lat_d   = '0;
            state_d = S_READ;
         end
         S_READ: begin
            busy   = 1'b1;
            mem_oe = 1'b1;
            // Address and oe are held RD_LAT cycles; data is judged on the final one.
            if (lat_q == LAT_LAST) begin
               lat_d = '0;
               if (mismatch) begin
                  if (err_q != 6'd63) begin
                     err_d = err_q + 6'd1;
                  end
                  if (!fev_q) begin
                     fev_d = 1'b1;
                     fea_d = addr_q;
                  end
               end
               if (addr_q == ADDR_MAX) begin
                  addr_d  = '0;
                  state_d = S_TURN_R;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         S_TURN_R: begin
            busy = 1'b1;
            if (TWO_PASS && !inv_q) begin
               inv_d   = 1'b1;
               state_d = S_WRITE;
            end else begin
               pass_d  = (err_q == 6'd0);
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
